// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus the launch/done link to the shared UART send logic.
// master = environment (requesters and send logic), slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_FRAME_WIDTH = 8
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ*DATA_FRAME_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                uart_tx_en;
    logic [0:DATA_FRAME_WIDTH-1]         uart_tx_din;
    logic                                uart_tx_done;

    modport master (
        output req_valid, req_data, uart_tx_done,
        input  req_ready, uart_tx_en, uart_tx_din
    );

    modport slave (
        input  req_valid, req_data, uart_tx_done,
        output req_ready, uart_tx_en, uart_tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART send logic among NUM_REQ requesters.
// One frame per grant; launch is tracked through done falling (WAIT_LOW, with
// timeout) and done rising again (WAIT_DONE). All outputs are registered.
module uart_tx_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_FRAME_WIDTH = 8,
    parameter int LAUNCH_TIMEOUT   = 16,
    parameter int CNT_WIDTH        = 16,
    localparam int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 bit_clk,
    input  logic                 reset_n,
    uart_tx_arbiter_if.slave     bus,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 sent_pulse,
    output logic [ID_W-1:0]      sent_id,
    output logic                 launch_err,
    output logic [CNT_WIDTH-1:0] frame_cnt
);
    localparam int TW = $clog2(LAUNCH_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_DONE} state_t;

    state_t                      state, state_n;
    logic [TW-1:0]               timer, timer_n;
    logic [ID_W-1:0]             rr_ptr, rr_n;
    logic [ID_W-1:0]             pick;
    logic                        pick_vld;
    logic                        en_n, busy_n, sent_pulse_n, err_n;
    logic [NUM_REQ-1:0]          ready_n;
    logic [0:DATA_FRAME_WIDTH-1] din_n;
    logic [ID_W-1:0]             grant_n, sent_id_n;
    logic [CNT_WIDTH-1:0]        cnt_n;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick     = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        rr_n         = rr_ptr;
        en_n         = 1'b0;
        ready_n      = '0;
        din_n        = bus.uart_tx_din;
        grant_n      = grant_id;
        sent_pulse_n = 1'b0;
        sent_id_n    = sent_id;
        err_n        = 1'b0;
        cnt_n        = frame_cnt;
        case (state)
            IDLE: begin
                // Only grant when the send logic is idle.
                if (bus.uart_tx_done && pick_vld) begin
                    state_n = ISSUE;
                    en_n    = 1'b1;
                    ready_n = NUM_REQ'(1) << pick;
                    din_n   = bus.req_data[int'(pick)*DATA_FRAME_WIDTH +: DATA_FRAME_WIDTH];
                    grant_n = pick;
                    rr_n    = ID_W'((int'(pick) + 1) % NUM_REQ);
                end
            end
            ISSUE: begin
                state_n = WAIT_LOW;
                timer_n = '0;
            end
            WAIT_LOW: begin
                if (!bus.uart_tx_done) begin
                    state_n = WAIT_DONE;
                end else if (timer == TW'(LAUNCH_TIMEOUT - 1)) begin
                    // Send logic never picked the frame up; give up on it.
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.uart_tx_done) begin
                    sent_pulse_n = 1'b1;
                    sent_id_n    = grant_id;
                    cnt_n        = frame_cnt + CNT_WIDTH'(1);
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge bit_clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            timer           <= '0;
            rr_ptr          <= '0;
            bus.uart_tx_en  <= 1'b0;
            bus.req_ready   <= '0;
            bus.uart_tx_din <= '0;
            grant_id        <= '0;
            busy            <= 1'b0;
            sent_pulse      <= 1'b0;
            sent_id         <= '0;
            launch_err      <= 1'b0;
            frame_cnt       <= '0;
        end else begin
            state           <= state_n;
            timer           <= timer_n;
            rr_ptr          <= rr_n;
            bus.uart_tx_en  <= en_n;
            bus.req_ready   <= ready_n;
            bus.uart_tx_din <= din_n;
            grant_id        <= grant_n;
            busy            <= busy_n;
            sent_pulse      <= sent_pulse_n;
            sent_id         <= sent_id_n;
            launch_err      <= err_n;
            frame_cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of frames plus hand sequences for held
// fairness, launch timeout and reset mid-frame. Expected grants go through a queue.
module tb_uart_tx_arbiter;
    logic        bit_clk = 1'b0;
    logic        reset_n;
    logic        busy, sent_pulse, launch_err;
    logic [1:0]  grant_id, sent_id;
    logic [15:0] frame_cnt;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_FRAME_WIDTH(8)) intf ();

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_FRAME_WIDTH(8), .LAUNCH_TIMEOUT(16), .CNT_WIDTH(16)
    ) dut (
        .bit_clk(bit_clk), .reset_n(reset_n), .bus(intf), .busy(busy),
        .grant_id(grant_id), .sent_pulse(sent_pulse), .sent_id(sent_id),
        .launch_err(launch_err), .frame_cnt(frame_cnt)
    );

    always #5 bit_clk = ~bit_clk;

    // Send logic model: done falls 1 cycle after en, rises 10 cycles later.
    logic done_m = 1'b1;
    logic stuck  = 1'b0;
    int   busy_cnt = 0;
    always @(posedge bit_clk) begin
        if (stuck) begin
            done_m <= 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) done_m <= 1'b1;
        end else if (intf.uart_tx_en) begin
            done_m   <= 1'b0;
            busy_cnt <= 10;
        end
    end
    assign intf.uart_tx_done = done_m;

    typedef struct { logic [3:0] valid; logic [31:0] data; int exp_id; logic [7:0] exp_din; } vec_t;
    typedef struct { int id; logic [7:0] din; } exp_t;

    vec_t vt[12];
    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge bit_clk);
    endtask

    // Wait for the launch strobe and compare it with the oldest expected grant.
    task automatic wait_en();
        int k;
        exp_t e;
        logic [3:0] one;
        logic [7:0] d;
        k = 0;
        while (!intf.uart_tx_en && k < 60) begin tick(); k++; end
        if (!intf.uart_tx_en) begin chk("en_timeout", 32'd0, 32'd1); return; end
        if (q.size() == 0) begin chk("unexpected_en", 32'd1, 32'd0); return; end
        e   = q.pop_front();
        one = 4'b0001;
        d   = intf.uart_tx_din;
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("din", 32'(d), 32'(e.din));
        chk("ready", 32'(intf.req_ready), 32'(one << e.id));
        chk("busy_issue", 32'(busy), 32'd1);
    endtask

    // Wait for completion and check id and running count.
    task automatic wait_sent(input int id);
        int k;
        k = 0;
        while (!sent_pulse && k < 60) begin tick(); k++; end
        if (!sent_pulse) begin chk("sent_timeout", 32'd0, 32'd1); return; end
        exp_cnt++;
        chk("sent_id", 32'(sent_id), 32'(id));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int k;
        logic seen;
        logic [7:0] d;

        vt[0]  = '{4'b0100, 32'h00A50000, 2, 8'hA5};
        vt[1]  = '{4'b1000, 32'h5A000000, 3, 8'h5A};
        vt[2]  = '{4'b1111, 32'h44332211, 0, 8'h11};
        vt[3]  = '{4'b1111, 32'h44332211, 1, 8'h22};
        vt[4]  = '{4'b1111, 32'h44332211, 2, 8'h33};
        vt[5]  = '{4'b1111, 32'h44332211, 3, 8'h44};
        vt[6]  = '{4'b1111, 32'h44332211, 0, 8'h11};
        vt[7]  = '{4'b1111, 32'h44332211, 1, 8'h22};
        vt[8]  = '{4'b0011, 32'h0000BBAA, 0, 8'hAA};
        vt[9]  = '{4'b0011, 32'h0000BBAA, 1, 8'hBB};
        vt[10] = '{4'b0110, 32'h00C2C100, 2, 8'hC2};
        vt[11] = '{4'b0110, 32'h00C2C100, 1, 8'hC1};

        // Reset with random request noise: everything stays quiet.
        reset_n = 1'b0;
        intf.req_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            intf.req_valid = 4'($urandom);
            tick();
        end
        d = intf.uart_tx_din;
        chk("reset_outs", {4'd0, intf.uart_tx_en, intf.req_ready, busy, grant_id, sent_pulse,
                           sent_id, launch_err, frame_cnt}, 32'd0);
        chk("reset_din", 32'(d), 32'd0);
        intf.req_valid = '0;
        reset_n = 1'b1;
        tick();

        // Table: one frame per record, requester drops valid once acked.
        for (int i = 0; i < 12; i++) begin
            intf.req_valid = vt[i].valid;
            intf.req_data  = vt[i].data;
            q.push_back('{vt[i].exp_id, vt[i].exp_din});
            wait_en();
            intf.req_valid = '0;
            wait_sent(vt[i].exp_id);
        end

        // Held fairness with back-to-back frames: one IDLE cycle between frames.
        intf.req_valid = 4'b1111;
        intf.req_data  = 32'h44332211;
        q.push_back('{2, 8'h33});
        q.push_back('{3, 8'h44});
        q.push_back('{0, 8'h11});
        q.push_back('{1, 8'h22});
        wait_en();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) intf.req_valid = '0;
            wait_sent((i + 2) % 4);
            if (i < 3) begin
                chk("spacing_idle", 32'(intf.uart_tx_en), 32'd0);
                tick();
                chk("spacing_next", 32'(intf.uart_tx_en), 32'd1);
                wait_en();
            end
        end

        // Launch timeout: done never falls. Pointer is at 2, so 0001 grants 0.
        tick();
        stuck = 1'b1;
        intf.req_valid = 4'b0001;
        intf.req_data  = 32'h000000E7;
        q.push_back('{0, 8'hE7});
        wait_en();
        intf.req_valid = '0;
        seen = 1'b0;
        for (int i = 1; i < 17; i++) begin
            tick();
            seen = seen | launch_err | sent_pulse;
        end
        chk("err_early", 32'(seen), 32'd0);
        tick();
        chk("launch_err", 32'(launch_err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_sent", 32'(sent_pulse), 32'd0);
        chk("err_cnt", 32'(frame_cnt), 32'(exp_cnt));
        stuck = 1'b0;
        tick();

        // Reset mid-frame: pointer returns to 0, no grant until done rises.
        intf.req_valid = 4'b0100;
        intf.req_data  = 32'h00D40000;
        q.push_back('{2, 8'hD4});
        wait_en();
        intf.req_valid = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_wait_done", {30'd0, busy, done_m}, 32'd2);
        reset_n = 1'b0;
        intf.req_valid = 4'b1010;
        intf.req_data  = 32'h77006600;
        tick();
        chk("mid_reset_outs", {4'd0, intf.uart_tx_en, intf.req_ready, busy, grant_id, sent_pulse,
                               sent_id, launch_err, frame_cnt}, 32'd0);
        reset_n = 1'b1;
        exp_cnt = 0;
        seen = 1'b0;
        k = 0;
        while (!done_m && k < 30) begin
            tick();
            seen = seen | intf.uart_tx_en;
            k++;
        end
        chk("no_grant_while_busy", 32'(seen), 32'd0);
        q.push_back('{1, 8'h66});
        wait_en();
        intf.req_valid = 4'b1000;
        wait_sent(1);
        q.push_back('{3, 8'h77});
        wait_en();
        intf.req_valid = '0;
        wait_sent(3);

        if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
